// File: rtl/uart_ctrl.sv
// UART register-bus controller: programs divisor/LCR, then polls LSR
// to move bytes from a small TX FIFO into THR and from RBR to rx_data_o.
module uart_ctrl #(
  parameter logic [15:0] DIVISOR   = 16'd27,
  parameter logic [7:0]  LCR_VAL   = 8'h03,
  parameter int          TXQ_DEPTH = 4
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  input  logic       rx_ready_i,
  output logic       uart_wen_o,
  output logic       uart_ren_o,
  output logic [2:0] uart_addr_o,
  output logic [7:0] uart_wdata_o,
  input  logic [7:0] uart_rdata_i,
  output logic       init_done_o
);

  localparam int PW = $clog2(TXQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [3:0] {
    INIT_LCRD,
    INIT_DLL,
    INIT_DLM,
    INIT_LCR,
    POLL_REQ,
    POLL_CHK,
    RD_REQ,
    RD_CAP,
    WR_THR
  } state_e;

  state_e          state_q, state_d;
  logic            wen_q, wen_d;
  logic            ren_q, ren_d;
  logic [2:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            init_done_q, init_done_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [7:0]      mem_q [TXQ_DEPTH];
  logic [7:0]      mem_d [TXQ_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push, pop, rx_free;

  assign tx_ready_o   = init_done_q && (cnt_q < CW'(TXQ_DEPTH));
  assign rx_valid_o   = rx_valid_q;
  assign rx_data_o    = rx_data_q;
  assign uart_wen_o   = wen_q;
  assign uart_ren_o   = ren_q;
  assign uart_addr_o  = addr_q;
  assign uart_wdata_o = wdata_q;
  assign init_done_o  = init_done_q;

  always_comb begin
    push        = tx_valid_i && tx_ready_o;
    pop         = (state_q == WR_THR);
    rx_free     = !rx_valid_q || rx_ready_i;
    state_d     = state_q;
    init_done_d = init_done_q;
    rx_valid_d  = rx_valid_q && !rx_ready_i;
    rx_data_d   = rx_data_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    addr_d      = 3'd0;
    wdata_d     = 8'h00;

    // Reset leaves LCRD with its strobe low; the strobe marks it as issued.
    unique case (state_q)
      INIT_LCRD: if (wen_q) state_d = INIT_DLL;
      INIT_DLL:  state_d = INIT_DLM;
      INIT_DLM:  state_d = INIT_LCR;
      INIT_LCR: begin
        state_d     = POLL_REQ;
        init_done_d = 1'b1;
      end
      POLL_REQ:  state_d = POLL_CHK;
      POLL_CHK: begin
        if (uart_rdata_i[0] && rx_free)
          state_d = RD_REQ;
        else if (uart_rdata_i[5] && cnt_q != '0)
          state_d = WR_THR;
        else
          state_d = POLL_REQ;
      end
      RD_REQ:    state_d = RD_CAP;
      RD_CAP: begin
        state_d    = POLL_REQ;
        rx_valid_d = 1'b1;
        rx_data_d  = uart_rdata_i;
      end
      WR_THR:    state_d = POLL_REQ;
      default:   state_d = INIT_LCRD;
    endcase

    unique case (state_d)
      INIT_LCRD: begin
        wen_d   = 1'b1;
        addr_d  = 3'd3;
        wdata_d = 8'h80 | LCR_VAL;
      end
      INIT_DLL: begin
        wen_d   = 1'b1;
        addr_d  = 3'd0;
        wdata_d = DIVISOR[7:0];
      end
      INIT_DLM: begin
        wen_d   = 1'b1;
        addr_d  = 3'd1;
        wdata_d = DIVISOR[15:8];
      end
      INIT_LCR: begin
        wen_d   = 1'b1;
        addr_d  = 3'd3;
        wdata_d = LCR_VAL;
      end
      POLL_REQ: begin
        ren_d  = 1'b1;
        addr_d = 3'd5;
      end
      RD_REQ: begin
        ren_d  = 1'b1;
        addr_d = 3'd0;
      end
      WR_THR: begin
        wen_d   = 1'b1;
        addr_d  = 3'd0;
        wdata_d = mem_q[rd_ptr_q];
      end
      default: ;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = tx_data_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= INIT_LCRD;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      addr_q      <= 3'd0;
      wdata_q     <= 8'h00;
      init_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      init_done_q <= init_done_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter DIVISOR, default 16'd27, baud divisor loaded into DLL/DLM at init.
REQ-002 SHALL have parameter LCR_VAL, default 8'h03, line control value (8N1) written after the divisor.
REQ-003 SHALL have parameter TXQ_DEPTH, default 4, transmit queue entries (power of two, 2..16).
REQ-004 SHALL have port clk_in  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port tx_valid_i  in  1  byte offered for transmit.
REQ-007 SHALL have port tx_data_i  in  8  transmit byte.
REQ-008 SHALL have port tx_ready_o  out  1  queue accepts a byte this cycle.
REQ-009 SHALL have port rx_valid_o  out  1  received byte held.
REQ-010 SHALL have port rx_data_o  out  8  received byte.
REQ-011 SHALL have port rx_ready_i  in  1  consumer takes rx_data_o.
REQ-012 SHALL have port uart_wen_o  out  1  UART register write strobe.
REQ-013 SHALL have port uart_ren_o  out  1  UART register read strobe.
REQ-014 SHALL have port uart_addr_o  out  3  UART register address.
REQ-015 SHALL have port uart_wdata_o  out  8  UART write data.
REQ-016 SHALL have port uart_rdata_i  in  8  UART read data, valid the cycle after uart_ren_o.
REQ-017 SHALL have port init_done_o  out  1  configuration sequence complete.

Function
REQ-018 SHALL use one FSM: INIT_LCRD, INIT_DLL, INIT_DLM, INIT_LCR, POLL_REQ, POLL_CHK, RD_REQ, RD_CAP, WR_THR.
REQ-019 SHALL, in init states (one cycle each), write: addr 3 = 8'h80|LCR_VAL; addr 0 = DIVISOR[7:0]; addr 1 = DIVISOR[15:8]; addr 3 = LCR_VAL; then set init_done_o=1 and enter POLL_REQ.
REQ-020 SHALL, in POLL_REQ, assert uart_ren_o with addr 5 (LSR) for one cycle; POLL_CHK samples uart_rdata_i (bit0=DR, bit5=THRE).
REQ-021 SHALL, from POLL_CHK, go to RD_REQ if DR=1 and RX slot free (rx_valid_o=0, or rx_ready_i=1 that cycle).
REQ-022 SHALL, else from POLL_CHK, go to WR_THR if THRE=1 and queue non-empty; otherwise return to POLL_REQ.
REQ-023 SHALL give RX priority over TX when both are eligible in POLL_CHK.
REQ-024 SHALL, in RD_REQ, assert uart_ren_o with addr 0; in RD_CAP, load rx_data_o from uart_rdata_i, set rx_valid_o=1, go to POLL_REQ.
REQ-025 SHALL, in WR_THR, assert uart_wen_o with addr 0 and uart_wdata_o = queue head, pop one entry, go to POLL_REQ.
REQ-026 SHALL never assert uart_wen_o and uart_ren_o in the same cycle; both SHALL be 0 when not listed above, with uart_addr_o/uart_wdata_o 0.
REQ-027 SHALL clear rx_valid_o the cycle after rx_valid_o && rx_ready_i, unless RD_CAP reloads it that same cycle (reload wins).
REQ-028 SHALL implement the queue as a circular FIFO with wrapping read/write pointers and a count of width clog2(TXQ_DEPTH)+1.
REQ-029 SHALL drive tx_ready_o = init_done_o && (count < TXQ_DEPTH); push occurs on tx_valid_i && tx_ready_o.
REQ-030 SHALL, on simultaneous push and pop, leave count unchanged; when full, tx_ready_o SHALL stay 0 even in a pop cycle.
REQ-031 SHALL preserve byte order: bytes reach uart_wdata_o in acceptance order.
REQ-032 SHALL have latency from LSR read to THR write of exactly 2 cycles (POLL_REQ, POLL_CHK, WR_THR).

Reset
REQ-033 SHALL, on rst=1 at a clock edge, enter INIT_LCRD, empty the queue, and clear rx_valid_o, rx_data_o, init_done_o, tx_ready_o, uart_wen_o, uart_ren_o, uart_addr_o, uart_wdata_o to 0.
REQ-034 SHALL, on rst mid-operation, abandon the access in flight, discard queued bytes and rerun the full init sequence.

Verification
REQ-035 SHALL cover: release reset, DIVISOR=16'd27 -> writes (3,8'h83),(0,8'h1B),(1,8'h00),(3,8'h03) on 4 consecutive cycles, then init_done_o=1.
REQ-036 SHALL cover: push 8'hA5,8'h5A, LSR model returns 8'h20 -> THR writes 8'hA5 then 8'h5A in order, count returns to 0.
REQ-037 SHALL cover: push 4 bytes with LSR=8'h00 -> tx_ready_o=0 after 4th; 5th byte not accepted; LSR=8'h20 -> exactly 4 writes.
REQ-038 SHALL cover: LSR=8'h21, RBR=8'h3C, queue non-empty -> RBR read precedes THR write; rx_data_o=8'h3C, rx_valid_o=1.
REQ-039 SHALL cover: rx_valid_o=1 held with rx_ready_i=0, LSR=8'h01 -> no RBR read until rx_ready_i=1; byte not overwritten.
REQ-040 SHALL cover: rst=1 during WR_THR with 3 bytes queued -> all outputs 0 next cycle, queue empty, init sequence repeats.
